// File: rtl/gate_pkg.sv
// Shared constants for the gate input conditioning path: debounce FSM encoding and defaults.
// Latency: n/a (package). Backpressure: n/a.
package gate_pkg;

    localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH   = 2'd1;
    localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW    = 2'd3;

    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_W_DEF           = 20;

    // Output level implied by a state: high once a rise has been accepted until a fall is.
    function automatic logic state_is_high(input logic [1:0] st);
        return (st == ST_STABLE_HIGH) || (st == ST_WAIT_LOW);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One-bit debouncer: 2-flop synchroniser, stability counter FSM, optional edge pulses (DEBOUNCE_EDGE_PULSE_EN).
// Latency: raw change captured at edge k shows on clean_o at edge k+DEBOUNCE_CYCLES+1.
// Backpressure: none; free-running level path.
import gate_pkg::*;

module debounce_channel #(
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_STABLE_LOW: begin
                if (sync2_q) begin
                    state_d = ST_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STABLE_HIGH: begin
                if (!sync2_q) begin
                    state_d = ST_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (sync2_q) begin
                    state_d = ST_STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // clean_q is decoded from the next state so it tracks state_q with no extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_STABLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= state_is_high(state_d);
        end
    end

    assign clean_o = clean_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    logic prev_q, rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= clean_q;
            rise_q <= clean_q & ~prev_q;
            fall_q <= ~clean_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: rtl/gate_input_debouncer.sv
// Debounces N_CH raw pin levels (A=bit0, B=bit1) for the gate inputs; edge pulses under DEBOUNCE_EDGE_PULSE_EN.
// Latency: DEBOUNCE_CYCLES+1 edges from first capture of a raw change.
// Backpressure: none; channels independent.
import gate_pkg::*;

module gate_input_debouncer #(
    parameter int N_CH            = 2,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] clean_out
`ifdef DEBOUNCE_EDGE_PULSE_EN
    ,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
`endif
);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (raw_in[g]),
            .clean_o(clean_out[g])
`ifdef DEBOUNCE_EDGE_PULSE_EN
            ,
            .rise_o (rise_pulse[g]),
            .fall_o (fall_pulse[g])
`endif
        );
    end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Scoreboarded bench for gate_input_debouncer with DEBOUNCE_CYCLES=4, CNT_W=3.
module tb_gate_input_debouncer;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] raw_in;
    logic [1:0] clean_out;
    logic [1:0] rise_pulse, fall_pulse;
    logic       gate_c;

    always #5 clk = ~clk;

`ifdef DEBOUNCE_EDGE_PULSE_EN
    gate_input_debouncer #(.N_CH(2), .CNT_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .clean_out(clean_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse));
`else
    gate_input_debouncer #(.N_CH(2), .CNT_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .raw_in(raw_in), .clean_out(clean_out));
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

    // Downstream OR gate fed by the debounced A/B levels.
    assign gate_c = clean_out[0] | clean_out[1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a channel flips once sync2 has disagreed with it for D consecutive samples.
    logic [1:0] m_s1 = '0, m_s2 = '0, m_clean = '0, m_prev = '0, m_rise = '0, m_fall = '0;
    int         m_run [2] = '{0, 0};

    typedef struct packed {
        logic [1:0] clean;
        logic [1:0] rise;
        logic [1:0] fall;
    } exp_t;
    exp_t sb_q[$];

    task automatic model_edge(input logic r, input logic [1:0] raw);
        logic [1:0] nclean;
        nclean = m_clean;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_clean = '0; m_prev = '0; m_rise = '0; m_fall = '0;
            m_run[0] = 0; m_run[1] = 0;
        end else begin
            m_rise = m_clean & ~m_prev;
            m_fall = ~m_clean & m_prev;
            m_prev = m_clean;
            for (int ch = 0; ch < 2; ch++) begin
                if (m_s2[ch] != m_clean[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        nclean[ch] = m_s2[ch];
                        m_run[ch]  = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            m_clean = nclean;
            m_s2    = m_s1;
            m_s1    = raw;
        end
    endtask

    // One clock: drive, predict, then compare the DUT just after the edge.
    task automatic cyc(input logic r, input logic [1:0] raw);
        exp_t e;
        @(negedge clk);
        rst    = r;
        raw_in = raw;
        model_edge(r, raw);
        sb_q.push_back({m_clean, m_rise, m_fall});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("sb_clean", 32'(clean_out), 32'(e.clean));
`ifdef DEBOUNCE_EDGE_PULSE_EN
            chk("sb_rise", 32'(rise_pulse), 32'(e.rise));
            chk("sb_fall", 32'(fall_pulse), 32'(e.fall));
`endif
        end
    endtask

    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int rise_idx, rise_cnt, pulse_cnt, r0, r1, f0, f1;
        logic prev0, prev1;
        rst    = 1'b1;
        raw_in = 2'b11;

        // Reset holds everything low even with raw high.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b11);
            chk("rst_clean", 32'(clean_out), 32'd0);
            chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'd0);
        end

        // A rises: clean at edge 5, not before; rise pulse after edge 6 only.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 2'b01);
            chk("t2_pre", 32'(clean_out[0]), 32'd0);
        end
        cyc(1'b0, 2'b01);
        chk("t2_rise", 32'(clean_out[0]), 32'd1);
        cyc(1'b0, 2'b01);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        chk("t2_pulse_on", 32'(rise_pulse[0]), 32'd1);
`endif
        cyc(1'b0, 2'b01);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        chk("t2_pulse_off", 32'(rise_pulse[0]), 32'd0);
`endif

        // B high for 3 cycles only: rejected.
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b11);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'b01);
            chk("t3_b_low", 32'({clean_out[1], rise_pulse[1], fall_pulse[1]}), 32'd0);
        end

        // Bounce on A, then held: one rise, 5 edges after final capture.
        for (int i = 0; i < 8; i++) cyc(1'b0, 2'b00);
        chk("t4_settled", 32'(clean_out), 32'd0);
        rise_idx = -1; rise_cnt = 0; pulse_cnt = 0; prev0 = clean_out[0];
        for (int i = 0; i < 14; i++) begin
            cyc(1'b0, (i < 5) ? {1'b0, pat[i]} : 2'b01);
            if (clean_out[0] && !prev0) begin
                rise_cnt++;
                rise_idx = i;
            end
            if (rise_pulse[0]) pulse_cnt++;
            prev0 = clean_out[0];
        end
        chk("t4_rise_edge", 32'(rise_idx), 32'd9);
        chk("t4_rise_cnt", 32'(rise_cnt), 32'd1);
`ifdef DEBOUNCE_EDGE_PULSE_EN
        chk("t4_pulse_cnt", 32'(pulse_cnt), 32'd1);
`endif

        // Simultaneous change on A and B settles on the same edge, both directions.
        for (int i = 0; i < 8; i++) cyc(1'b0, 2'b00);
        r0 = -1; r1 = -1; prev0 = clean_out[0]; prev1 = clean_out[1];
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'b11);
            if (clean_out[0] && !prev0) r0 = i;
            if (clean_out[1] && !prev1) r1 = i;
            prev0 = clean_out[0]; prev1 = clean_out[1];
        end
        chk("t5_rise_a", 32'(r0), 32'd5);
        chk("t5_rise_b", 32'(r1), 32'd5);
        f0 = -1; f1 = -1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'b00);
            if (!clean_out[0] && prev0) f0 = i;
            if (!clean_out[1] && prev1) f1 = i;
            prev0 = clean_out[0]; prev1 = clean_out[1];
        end
        chk("t5_fall_a", 32'(f0), 32'd5);
        chk("t5_fall_b", 32'(f1), 32'd5);

        // Reset mid-WAIT_HIGH discards the count; full latency after release.
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b01);
        cyc(1'b1, 2'b01);
        chk("t6_rst_clean", 32'(clean_out[0]), 32'd0);
        chk("t6_c_low", 32'(gate_c), 32'd0);
        r0 = -1; prev0 = clean_out[0];
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 2'b01);
            if (clean_out[0] && !prev0) r0 = i;
            prev0 = clean_out[0];
        end
        chk("t6_rise_edge", 32'(r0), 32'd5);
        chk("t6_c_high", 32'(gate_c), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
